mfp_sprite_table_scanner: RTL and testbench
===========================================

Name: mfp_sprite_table_scanner

Overview:
Per-scanline sequencer for the sprite table RAM's read port. On each line_start pulse it walks the table entry by entry and tests every enabled sprite against the current scanline. Each hit is streamed to the sprite line renderer over a valid/ready handshake. It sits between the VGA timing generator and the renderer. The AHB side keeps the write port, and this block is the sole driver of the table read address.

Parameters:
ADDR_W, 6, sprite table word-address width
N_ENTRIES, 64, entries scanned per line (1..2**ADDR_W)
SPR_H, 32, sprite height in lines (power of two, 2..512)
MAX_HITS, 8, maximum hits emitted per line (1..N_ENTRIES)

Ports:
HCLK  in  1  system clock
HRESETn  in  1  asynchronous active-low reset
line_start  in  1  one-cycle pulse: begin scan for line_y
line_y  in  10  scanline number; sampled only when line_start=1
tbl_addr  out  ADDR_W  sprite table read word address
tbl_rdata  in  32  table read data; synchronous read, valid 1 cycle after tbl_addr
out_valid  out  1  hit record valid
out_ready  in  1  renderer accepts the hit record
out_x  out  10  hit sprite X
out_row  out  log2(SPR_H)  row within the sprite, line_y - spr_y
out_img  out  7  hit sprite image id
busy  out  1  scan in progress
done  out  1  one-cycle pulse when a scan completes
line_full  out  1  last scan stopped at MAX_HITS; held until next line_start
overrun  out  1  one-cycle pulse when line_start aborts a running scan

Behaviour:
- Entry format:
  - [31] enable
  - [30:24] img
  - [23:20] reserved, ignored
  - [19:10] x
  - [9:0] y
- Hit rule: enable=1, line_y >= y, and (line_y - y) < SPR_H.
  - Compare is unsigned 10-bit. No wrap: y > line_y is never a hit.
  - out_row is the low log2(SPR_H) bits of line_y - y.
- Reset values: state IDLE, tbl_addr=0, idx=0, hit_cnt=0, out_valid=0, busy=0, done=0, line_full=0, overrun=0. Captured line_y resets to 0.
- FSM, 2 cycles per entry:
  - IDLE: tbl_addr=0. On line_start: capture line_y, idx=0, hit_cnt=0, line_full=0, go FETCH.
  - FETCH: tbl_addr=idx; go EVAL next cycle.
  - EVAL on a hit: out_valid=1 (combinational from state, tbl_rdata and captured line_y). out_x, out_row and out_img are driven from tbl_rdata.
    - Stall while out_ready=0. tbl_addr is held, so tbl_rdata stays stable.
    - On out_ready=1: hit_cnt++, then advance.
  - EVAL on a non-hit: advance immediately. out_valid stays 0.
  - Advance:
    - If hit_cnt (after increment) == MAX_HITS, set line_full and go DONE.
    - Else if idx == N_ENTRIES-1, go DONE.
    - Else idx++ and go FETCH.
  - DONE: pulse done for 1 cycle, go IDLE.
- busy=1 in FETCH and EVAL.
- out_valid, once asserted, stays asserted with stable fields until accepted, except on an abort.
- line_start in FETCH or EVAL:
  - Abort the scan and pulse overrun the same cycle. No done pulse for the aborted scan.
  - Restart as from IDLE with the new line_y. out_valid is 0 from the next cycle.
  - A handshake completing in the same cycle as the abort is discarded.
- line_start in DONE: done still pulses and the new scan starts the same cycle, i.e. DONE goes directly to FETCH.
- Total scan latency with no stalls and MAX_HITS not reached: 2*N_ENTRIES + 1 cycles from line_start to done.
- HRESETn assertion mid-scan forces all state to reset values immediately.

Decomposition:
- Shared constants go in the sprite include alongside the table address width:
  - entry field bit positions: enable, img, x, y
  - SPR_H default
  - state encodings: IDLE, FETCH, EVAL, DONE
- The hit-compare is a natural combinational sub-module: sprite_line_match (inputs entry, line_y; outputs hit, row).
- The FSM stays in the top.

Test Plan:
- N_ENTRIES=4. Table: e0={en=1,y=100,x=20,img=3}, rest disabled; line_y=110, out_ready=1 -> one record x=20,row=10,img=3; done 9 cycles after line_start; line_full=0.
- Boundary: e0 y=100. line_y=99 -> no hit; line_y=131 -> row=31; line_y=132 -> no hit; y=1000,line_y=5 -> no hit.
- Backpressure: two hits, out_ready low for 5 cycles on the first -> out_valid and fields stable through the stall, tbl_addr held; both accepted in table order.
- MAX_HITS=2 with 4 enabled hits -> exactly 2 records; done pulses after the 2nd acceptance; line_full=1 until the next line_start.
- line_start mid-EVAL with a pending unaccepted hit -> overrun pulse, no done; out_valid=0 next cycle; new scan restarts at tbl_addr=0 with the new line_y.
- HRESETn low during FETCH -> busy=0, out_valid=0, tbl_addr=0 immediately; after release, the next line_start scans normally.

Source files
------------

// File: rtl/mfp_sprite_table_scanner_pkg.sv
// Shared constants for the sprite table scanner: table geometry, entry field
// layout and scan sequencer state encoding.
package mfp_sprite_table_scanner_pkg;

    localparam int SPR_ADDR_W = 6;
    localparam int SPR_H_DEF  = 32;

    localparam int ENT_EN_BIT  = 31;
    localparam int ENT_IMG_MSB = 30;
    localparam int ENT_IMG_LSB = 24;
    localparam int ENT_X_MSB   = 19;
    localparam int ENT_X_LSB   = 10;
    localparam int ENT_Y_MSB   = 9;
    localparam int ENT_Y_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EVAL  = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

endpackage

// File: rtl/sprite_line_match.sv
// Tests one sprite table entry against a scanline and yields the row
// inside the sprite that the scanline crosses.
module sprite_line_match
    import mfp_sprite_table_scanner_pkg::*;
#(
    parameter int SPR_H = SPR_H_DEF
) (
    input  logic [31:0]                entry,
    input  logic [9:0]                 line_y,
    output logic                       hit,
    output logic [$clog2(SPR_H)-1:0]   row
);

    localparam int          ROW_W   = $clog2(SPR_H);
    localparam logic [10:0] SPR_H_L = 11'(SPR_H);

    logic [9:0] spr_y;
    logic [9:0] diff;
    logic       unused_fields;

    assign spr_y = entry[ENT_Y_MSB:ENT_Y_LSB];
    assign diff  = line_y - spr_y;

    // The line_y >= spr_y term rules out wrap-around hits for sprites below the line.
    assign hit = entry[ENT_EN_BIT] && (line_y >= spr_y) && ({1'b0, diff} < SPR_H_L);
    assign row = diff[ROW_W-1:0];

    assign unused_fields = ^entry[ENT_IMG_MSB:ENT_X_LSB];

endmodule

// File: rtl/mfp_sprite_table_scanner.sv
// Per-scanline sprite table walker: reads every entry through the table read
// port and streams hits to the line renderer over valid/ready.
module mfp_sprite_table_scanner
    import mfp_sprite_table_scanner_pkg::*;
#(
    parameter int ADDR_W    = SPR_ADDR_W,
    parameter int N_ENTRIES = 64,
    parameter int SPR_H     = SPR_H_DEF,
    parameter int MAX_HITS  = 8
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    input  logic                       line_start,
    input  logic [9:0]                 line_y,
    output logic [ADDR_W-1:0]          tbl_addr,
    input  logic [31:0]                tbl_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [9:0]                 out_x,
    output logic [$clog2(SPR_H)-1:0]   out_row,
    output logic [6:0]                 out_img,
    output logic                       busy,
    output logic                       done,
    output logic                       line_full,
    output logic                       overrun
);

    localparam int                ROW_W     = $clog2(SPR_H);
    localparam int                CNT_W     = $clog2(MAX_HITS + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_ENTRIES - 1);
    localparam logic [CNT_W-1:0]  HIT_LIMIT = CNT_W'(MAX_HITS);

    scan_state_t       state, state_next;
    logic [ADDR_W-1:0] idx, idx_next;
    logic [CNT_W-1:0]  hit_cnt, hit_cnt_next, cnt_inc;
    logic [9:0]        cur_y, cur_y_next;
    logic              line_full_next;
    logic              hit;
    logic [ROW_W-1:0]  row;

    sprite_line_match #(
        .SPR_H (SPR_H)
    ) u_match (
        .entry  (tbl_rdata),
        .line_y (cur_y),
        .hit    (hit),
        .row    (row)
    );

    assign out_x   = tbl_rdata[ENT_X_MSB:ENT_X_LSB];
    assign out_img = tbl_rdata[ENT_IMG_MSB:ENT_IMG_LSB];
    assign out_row = row;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            idx       <= '0;
            hit_cnt   <= '0;
            cur_y     <= '0;
            line_full <= 1'b0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            hit_cnt   <= hit_cnt_next;
            cur_y     <= cur_y_next;
            line_full <= line_full_next;
        end
    end

    always_comb begin
        state_next     = state;
        idx_next       = idx;
        hit_cnt_next   = hit_cnt;
        cur_y_next     = cur_y;
        line_full_next = line_full;
        cnt_inc        = hit_cnt + CNT_W'(hit);
        tbl_addr       = '0;
        busy           = 1'b0;
        done           = 1'b0;
        out_valid      = 1'b0;
        overrun        = 1'b0;

        case (state)
            ST_IDLE: state_next = ST_IDLE;
            ST_FETCH: begin
                busy       = 1'b1;
                tbl_addr   = idx;
                state_next = ST_EVAL;
            end
            ST_EVAL: begin
                // Address is held while stalled so the read data stays stable.
                busy      = 1'b1;
                tbl_addr  = idx;
                out_valid = hit;
                if (!hit || out_ready) begin
                    hit_cnt_next = cnt_inc;
                    if (hit && (cnt_inc == HIT_LIMIT)) begin
                        line_full_next = 1'b1;
                        state_next     = ST_DONE;
                    end else if (idx == LAST_IDX) begin
                        state_next = ST_DONE;
                    end else begin
                        idx_next   = idx + ADDR_W'(1);
                        state_next = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        // A new line always wins: restart from entry 0, dropping any pending handshake.
        if (line_start) begin
            overrun        = busy;
            state_next     = ST_FETCH;
            cur_y_next     = line_y;
            idx_next       = '0;
            hit_cnt_next   = '0;
            line_full_next = 1'b0;
        end
    end

endmodule

// File: tb/tb_mfp_sprite_table_scanner.sv
// Self-checking bench for mfp_sprite_table_scanner: directed scenarios plus
// randomized tables compared against a list-based reference model.
module tb_mfp_sprite_table_scanner;

    localparam int ADDR_W   = 6;
    localparam int N_ENT    = 4;
    localparam int SPR_H    = 32;
    localparam int MAX_HITS = 2;
    localparam int ROW_W    = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              line_start;
    logic [9:0]        line_y;
    logic [ADDR_W-1:0] tbl_addr;
    logic [31:0]       tbl_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [9:0]        out_x;
    logic [ROW_W-1:0]  out_row;
    logic [6:0]        out_img;
    logic              busy;
    logic              done;
    logic              line_full;
    logic              overrun;

    logic [31:0] mem [0:63];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic [31:0] got_q[$];

    logic [31:0] exp_q[$];
    bit          exp_full;
    int          exp_last;
    int          t0;
    int          rec_base;
    int          done_base;
    logic        ovr_seen;

    mfp_sprite_table_scanner #(
        .ADDR_W    (ADDR_W),
        .N_ENTRIES (N_ENT),
        .SPR_H     (SPR_H),
        .MAX_HITS  (MAX_HITS)
    ) dut (
        .HCLK       (clk),
        .HRESETn    (rst_n),
        .line_start (line_start),
        .line_y     (line_y),
        .tbl_addr   (tbl_addr),
        .tbl_rdata  (tbl_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x      (out_x),
        .out_row    (out_row),
        .out_img    (out_img),
        .busy       (busy),
        .done       (done),
        .line_full  (line_full),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tbl_rdata <= mem[tbl_addr];
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready && !line_start)
                got_q.push_back({10'd0, out_img, out_x, out_row});
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ent(input bit en, input int img, input int x, input int y);
        return {en, 7'(img), 4'hA, 10'(x), 10'(y)};
    endfunction

    // Reference: list every enabled entry whose sprite spans the line, in table order, capped at MAX_HITS.
    task automatic model(input int ly);
        logic [31:0] e;
        int sy;
        exp_q.delete();
        exp_full = 0;
        exp_last = N_ENT - 1;
        for (int i = 0; i < N_ENT; i++) begin
            e  = mem[i];
            sy = int'(e[9:0]);
            if (e[31] && ly >= sy && (ly - sy) < SPR_H) begin
                exp_q.push_back({10'd0, e[30:24], e[19:10], 5'(ly - sy)});
                if (exp_q.size() == MAX_HITS) begin
                    exp_full = 1;
                    exp_last = i;
                    break;
                end
            end
        end
    endtask

    task automatic begin_line(input logic [9:0] y);
        @(posedge clk);
        #1;
        line_start = 1'b1;
        line_y     = y;
        t0         = cyc;
        rec_base   = got_q.size();
        done_base  = done_cnt;
        @(negedge clk);
        ovr_seen = overrun;
        @(posedge clk);
        #1;
        line_start = 1'b0;
        line_y     = 10'($urandom);
    endtask

    task automatic finish_scan(input string tag, input int ly, input bit rnd, input bit chk_lat);
        int n;
        n = 0;
        model(ly);
        while (done_cnt == done_base && n < 300) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n++;
        end
        out_ready = 1'b1;
        check({tag, "_timeout"}, 32'(n < 300), 1);
        check({tag, "_count"}, got_q.size() - rec_base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (rec_base + i < got_q.size())
                check({tag, "_rec"}, got_q[rec_base + i], exp_q[i]);
        check({tag, "_full"}, line_full, exp_full);
        if (chk_lat) check({tag, "_lat"}, done_cyc - t0, 2 * (exp_last + 1) + 1);
    endtask

    task automatic set_far(input int ly);
        for (int i = 4; i < 8; i++) mem[i] = ent(1, i, i * 3, ly);
    endtask

    initial begin
        logic [21:0]       hold;
        logic [ADDR_W-1:0] hold_addr;
        int                n;
        int                ly;
        int                k;
        int                y;

        for (int i = 0; i < 64; i++) mem[i] = {1'b1, 31'($urandom)};
        rst_n      = 1'b0;
        line_start = 1'b0;
        line_y     = '0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_full", line_full, 0);
        check("rst_overrun", overrun, 0);
        check("rst_addr", tbl_addr, 0);
        rst_n = 1'b1;

        // Single hit, basic latency
        mem[0] = ent(1, 3, 20, 100);
        mem[1] = ent(0, 1, 1, 110);
        mem[2] = ent(0, 2, 2, 110);
        mem[3] = ent(0, 4, 4, 110);
        set_far(110);
        begin_line(110);
        finish_scan("basic", 110, 0, 1);
        check("basic_x", got_q[rec_base][14:5], 20);
        check("basic_row", got_q[rec_base][4:0], 10);

        // Boundaries around y=100
        begin_line(99);
        finish_scan("edge99", 99, 0, 1);
        begin_line(131);
        finish_scan("edge131", 131, 0, 1);
        begin_line(132);
        finish_scan("edge132", 132, 0, 1);
        mem[0] = ent(1, 3, 20, 1000);
        set_far(5);
        begin_line(5);
        finish_scan("nowrap", 5, 0, 1);

        // Backpressure on the first of two hits
        mem[0] = ent(1, 3, 20, 100);
        mem[1] = ent(1, 7, 40, 105);
        set_far(110);
        out_ready = 1'b0;
        begin_line(110);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_valid", out_valid, 1);
        hold      = {out_img, out_x, out_row};
        hold_addr = tbl_addr;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_fields", {out_img, out_x, out_row}, hold);
            check("bp_hold_addr", tbl_addr, hold_addr);
        end
        out_ready = 1'b1;
        finish_scan("bp", 110, 0, 0);

        // Hit cap
        mem[0] = ent(1, 1, 11, 100);
        mem[1] = ent(1, 2, 22, 101);
        mem[2] = ent(1, 3, 33, 102);
        mem[3] = ent(1, 4, 44, 103);
        begin_line(110);
        finish_scan("cap", 110, 0, 1);
        repeat (3) @(posedge clk);
        #1;
        check("cap_full_held", line_full, 1);
        set_far(5);
        begin_line(5);
        check("cap_full_clr", line_full, 0);
        finish_scan("cap_next", 5, 0, 1);

        // Abort a stalled hit with a new line
        mem[0] = ent(1, 3, 20, 100);
        mem[1] = ent(1, 9, 50, 200);
        mem[2] = ent(0, 0, 0, 0);
        mem[3] = ent(0, 0, 0, 0);
        set_far(210);
        out_ready = 1'b0;
        begin_line(110);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ab_pending", out_valid, 1);
        out_ready = 1'b1;
        begin_line(210);
        check("ab_overrun", ovr_seen, 1);
        check("ab_valid_drop", out_valid, 0);
        check("ab_addr", tbl_addr, 0);
        check("ab_busy", busy, 1);
        finish_scan("ab", 210, 0, 1);

        // Asynchronous reset during FETCH
        begin_line(210);
        check("rs_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rs_busy", busy, 0);
        check("rs_valid", out_valid, 0);
        check("rs_addr", tbl_addr, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        begin_line(210);
        finish_scan("rs_after", 210, 0, 1);

        // Randomized tables and backpressure
        for (int it = 0; it < 30; it++) begin
            ly = int'($urandom_range(0, 1023));
            for (int i = 0; i < N_ENT; i++) begin
                k = int'($urandom_range(0, 40)) - 4;
                y = ly - k;
                if (y < 0) y = 0;
                if (y > 1023) y = 1023;
                mem[i] = ent($urandom_range(0, 3) != 0, int'($urandom_range(0, 127)),
                             int'($urandom_range(0, 1023)), y);
            end
            set_far(ly);
            out_ready = 1'($urandom_range(0, 1));
            begin_line(10'(ly));
            finish_scan("rand", ly, 1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
